// File: rtl/downsample_pkg.sv
// Shared helpers for the downsample multiplier pipeline:
// product width, saturation bounds and rounding bias.
package downsample_pkg;

  function automatic int pw_f(input int w0, input int w1);
    return w0 + w1;
  endfunction

  function automatic longint sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  // Half of one output LSB, added before the shift.
  function automatic longint rnd_bias(input int sh);
    return (sh > 0) ? (64'sd1 <<< (sh - 1)) : 64'sd0;
  endfunction

endpackage

// File: rtl/downsample_mul_pipe_if.sv
// Stream bundle for the multiplier: input operands with
// valid/ready, and the result stream with valid/ready.
interface downsample_mul_pipe_if #(
  parameter int DIN0_WIDTH = 6,
  parameter int DIN1_WIDTH = 10,
  parameter int DOUT_WIDTH = 10
);
  logic                         in_valid;
  logic                         in_ready;
  logic        [DIN0_WIDTH-1:0] din0;
  logic signed [DIN1_WIDTH-1:0] din1;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DOUT_WIDTH-1:0] dout;
  logic                         sat_flag;

  modport master (
    output in_valid, din0, din1, out_ready,
    input  in_ready, out_valid, dout, sat_flag
  );

  modport slave (
    input  in_valid, din0, din1, out_ready,
    output in_ready, out_valid, dout, sat_flag
  );
endinterface

// File: rtl/downsample_mul_round_sat.sv
// Combinational multiply, rounding shift and
// saturate-or-wrap to the output width.
module downsample_mul_round_sat
  import downsample_pkg::*;
#(
  parameter int DIN0_WIDTH  = 6,
  parameter int DIN1_WIDTH  = 10,
  parameter int DOUT_WIDTH  = 10,
  parameter int DIN0_SIGNED = 0,
  parameter int SHIFT       = 0,
  parameter int SAT_EN      = 1
) (
  input  logic        [DIN0_WIDTH-1:0] din0,
  input  logic signed [DIN1_WIDTH-1:0] din1,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         sat_flag
);

  localparam int PW = pw_f(DIN0_WIDTH, DIN1_WIDTH);
  localparam int RW = PW + 1;

  localparam logic signed [RW-1:0] MAX_C =
    RW'(sat_max(DOUT_WIDTH));
  localparam logic signed [RW-1:0] MIN_C =
    RW'(sat_min(DOUT_WIDTH));
  localparam logic signed [RW-1:0] RND_C =
    RW'(rnd_bias(SHIFT));

  logic signed [DIN0_WIDTH:0] a;
  logic signed [RW-1:0]       a_x;
  logic signed [RW-1:0]       b_x;
  logic signed [RW-1:0]       p;
  logic signed [RW-1:0]       r;

  always_comb begin
    a = (DIN0_SIGNED != 0) ?
        {din0[DIN0_WIDTH-1], din0} :
        {1'b0, din0};
    a_x = RW'(a);
    b_x = RW'(din1);
    p   = a_x * b_x;
    // With SHIFT=0 the bias is zero and the shift is a no-op.
    r   = (p + RND_C) >>> SHIFT;
  end

  always_comb begin
    dout     = r[DOUT_WIDTH-1:0];
    sat_flag = 1'b0;
    if (SAT_EN != 0) begin
      if (r > MAX_C) begin
        dout     = MAX_C[DOUT_WIDTH-1:0];
        sat_flag = 1'b1;
      end else if (r < MIN_C) begin
        dout     = MIN_C[DOUT_WIDTH-1:0];
        sat_flag = 1'b1;
      end
    end
  end

endmodule

// File: rtl/downsample_mul_pipe.sv
// Pipelined multiplier: arithmetic ahead of stage 0, then
// delay stages with per-stage bubble-collapsing handshake.
module downsample_mul_pipe
  import downsample_pkg::*;
#(
  parameter int DIN0_WIDTH  = 6,
  parameter int DIN1_WIDTH  = 10,
  parameter int DOUT_WIDTH  = 10,
  parameter int NUM_STAGE   = 3,
  parameter int DIN0_SIGNED = 0,
  parameter int SHIFT       = 0,
  parameter int SAT_EN      = 1
) (
  input logic                 ap_clk,
  input logic                 ap_rst,
  downsample_mul_pipe_if.slave s
);

  localparam int LAST = NUM_STAGE - 1;

  logic signed [DOUT_WIDTH-1:0] res_dout;
  logic                         res_sat;

  logic [NUM_STAGE-1:0] adv;
  logic [NUM_STAGE-1:0] v_q, v_d;
  logic [NUM_STAGE-1:0] f_q, f_d;
  logic signed [DOUT_WIDTH-1:0] d_q [NUM_STAGE];
  logic signed [DOUT_WIDTH-1:0] d_d [NUM_STAGE];

  downsample_mul_round_sat #(
    .DIN0_WIDTH (DIN0_WIDTH),
    .DIN1_WIDTH (DIN1_WIDTH),
    .DOUT_WIDTH (DOUT_WIDTH),
    .DIN0_SIGNED(DIN0_SIGNED),
    .SHIFT      (SHIFT),
    .SAT_EN     (SAT_EN)
  ) u_mrs (
    .din0    (s.din0),
    .din1    (s.din1),
    .dout    (res_dout),
    .sat_flag(res_sat)
  );

  // Ready ripples back from the output; an empty stage always advances.
  always_comb begin
    logic run;
    run = !v_q[LAST] | s.out_ready;
    adv = '0;
    adv[LAST] = run;
    for (int i = LAST - 1; i >= 0; i--) begin
      run    = !v_q[i] | run;
      adv[i] = run;
    end
  end

  always_comb begin
    v_d = v_q;
    f_d = f_q;
    d_d = d_q;
    if (adv[0]) begin
      v_d[0] = s.in_valid;
      if (s.in_valid) begin
        d_d[0] = res_dout;
        f_d[0] = res_sat;
      end
    end
    for (int i = 1; i < NUM_STAGE; i++) begin
      if (adv[i]) begin
        v_d[i] = v_q[i-1];
        if (v_q[i-1]) begin
          d_d[i] = d_q[i-1];
          f_d[i] = f_q[i-1];
        end
      end
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      v_q <= '0;
      f_q <= '0;
      for (int i = 0; i < NUM_STAGE; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      v_q <= v_d;
      f_q <= f_d;
      for (int i = 0; i < NUM_STAGE; i++) begin
        d_q[i] <= d_d[i];
      end
    end
  end

  assign s.in_ready  = adv[0] & ~ap_rst;
  assign s.out_valid = v_q[LAST];
  assign s.dout      = d_q[LAST];
  assign s.sat_flag  = f_q[LAST];

endmodule

// File: tb/tb_downsample_mul_pipe.sv
// Directed bench: three configurations share one stimulus,
// each checked against hand-computed results.
module tb_downsample_mul_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              in_valid = 1'b0;
  logic [5:0]        din0 = '0;
  logic signed [9:0] din1 = '0;
  logic              out_ready = 1'b1;

  int n_chk = 0;
  int n_fail = 0;

  downsample_mul_pipe_if ifa ();
  downsample_mul_pipe_if ifb ();
  downsample_mul_pipe_if ifc ();

  assign ifa.in_valid = in_valid;
  assign ifa.din0 = din0;
  assign ifa.din1 = din1;
  assign ifa.out_ready = out_ready;
  assign ifb.in_valid = in_valid;
  assign ifb.din0 = din0;
  assign ifb.din1 = din1;
  assign ifb.out_ready = out_ready;
  assign ifc.in_valid = in_valid;
  assign ifc.din0 = din0;
  assign ifc.din1 = din1;
  assign ifc.out_ready = out_ready;

  downsample_mul_pipe dut_a (
    .ap_clk(clk), .ap_rst(rst), .s(ifa.slave)
  );
  downsample_mul_pipe #(.SAT_EN(0)) dut_b (
    .ap_clk(clk), .ap_rst(rst), .s(ifb.slave)
  );
  downsample_mul_pipe #(.SHIFT(2)) dut_c (
    .ap_clk(clk), .ap_rst(rst), .s(ifc.slave)
  );

  typedef struct {
    logic [5:0] d0;
    int d1;
    int ea; int sa;
    int eb; int sb;
    int ec; int sc;
  } vec_t;

  vec_t tv [12];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic send_one(input logic [5:0] d0, input int d1,
                          output int lat);
    @(negedge clk);
    din0 = d0;
    din1 = 10'(d1);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!ifa.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  int lat;
  int sent, recv, both, stale;

  initial begin
    tv[0]  = '{6'd5,  -7,   -35, 0,  -35, 0,   -9, 0};
    tv[1]  = '{6'd63, 511,  511, 1,  449, 0,  511, 1};
    tv[2]  = '{6'd63, -512, -512, 1, -512, 0, -512, 1};
    tv[3]  = '{6'd3,  3,      9, 0,    9, 0,    2, 0};
    tv[4]  = '{6'd3,  -3,    -9, 0,   -9, 0,   -2, 0};
    tv[5]  = '{6'd3,  2,      6, 0,    6, 0,    2, 0};
    tv[6]  = '{6'd0,  -512,   0, 0,    0, 0,    0, 0};
    tv[7]  = '{6'd1,  -512, -512, 0, -512, 0, -128, 0};
    tv[8]  = '{6'd8,  64,   511, 1, -512, 0,  128, 0};
    tv[9]  = '{6'd8,  -64,  -512, 0, -512, 0, -128, 0};
    tv[10] = '{6'd2,  255,  510, 0,  510, 0,  128, 0};
    tv[11] = '{6'd63, -1,   -63, 0,  -63, 0,  -16, 0};

    #1;
    chk("rst_out_valid", int'(ifa.out_valid), 0);
    chk("rst_dout", int'(ifa.dout), 0);
    chk("rst_sat", int'(ifa.sat_flag), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", int'(ifa.in_ready), 1);

    for (int i = 0; i < 12; i++) begin
      send_one(tv[i].d0, tv[i].d1, lat);
      chk($sformatf("lat_%0d", i), lat, 3);
      chk($sformatf("a_dout_%0d", i), int'(ifa.dout), tv[i].ea);
      chk($sformatf("a_sat_%0d", i), int'(ifa.sat_flag), tv[i].sa);
      chk($sformatf("b_dout_%0d", i), int'(ifb.dout), tv[i].eb);
      chk($sformatf("b_sat_%0d", i), int'(ifb.sat_flag), tv[i].sb);
      chk($sformatf("c_dout_%0d", i), int'(ifc.dout), tv[i].ec);
      chk($sformatf("c_sat_%0d", i), int'(ifc.sat_flag), tv[i].sc);
    end

    // Backpressure: output stalled for cycles 0..6.
    sent = 0;
    recv = 0;
    both = 0;
    for (int cyc = 0; cyc < 40 && recv < 6; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 7);
      in_valid = (sent < 6);
      din0 = 6'd1;
      din1 = 10'(10 + sent);
      #1;
      if (cyc == 5) begin
        chk("full_in_ready", int'(ifa.in_ready), 0);
        chk("full_sent", sent, 3);
        chk("stall_dout", int'(ifa.dout), 10);
      end
      if (cyc == 7) chk("release_in_ready", int'(ifa.in_ready), 1);
      if (in_valid && ifa.in_ready && ifa.out_valid && out_ready)
        both++;
      if (ifa.out_valid && out_ready) begin
        chk($sformatf("bp_order_%0d", recv), int'(ifa.dout), 10 + recv);
        recv++;
      end
      if (in_valid && ifa.in_ready) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_recv", recv, 6);
    chk("bp_sent", sent, 6);
    chk("bp_both_fire", int'(both > 0), 1);
    #1;
    chk("bp_drained", int'(ifa.out_valid), 0);

    // Async reset with three items held in a stalled pipe.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      din0 = 6'd5;
      din1 = -10'sd7;
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre_rst_valid", int'(ifa.out_valid), 1);
    chk("pre_rst_dout", int'(ifa.dout), -35);
    #1;
    rst = 1'b1;
    #1;
    chk("async_out_valid", int'(ifa.out_valid), 0);
    chk("async_dout", int'(ifa.dout), 0);
    chk("async_c_valid", int'(ifc.out_valid), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    stale = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      if (ifa.out_valid) stale++;
    end
    chk("no_stale", stale, 0);
    send_one(6'd3, 2, lat);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_a", int'(ifa.dout), 6);
    chk("post_rst_c", int'(ifc.dout), 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
